arduino_cmd_rx: RTL and testbench

//  Receives drive-command bytes from the Arduino over a UART line (8N1, LSB first).

---
 rtl/drive_cmd_pkg.sv | 33 +++
 rtl/arduino_cmd_rx_if.sv | 33 +++
 rtl/arduino_cmd_rx_uart_rx_core.sv | 141 ++++++++++++++
 rtl/arduino_cmd_rx.sv | 92 +++++++++
 tb/tb_arduino_cmd_rx.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/drive_cmd_pkg.sv
// -----------------------------------------------------------------------------
// drive_cmd_pkg
//   Drive-command byte codes understood by the vehicle, plus the legality test
//   used by the Arduino command receiver. Shared with the manual-mode FSM.
//   Contents:
//     CMD_*         8-bit command codes
//     is_legal_cmd  returns 1 when a received byte is one of the codes above
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package drive_cmd_pkg;

    localparam logic [7:0] CMD_STOP       = 8'h00;
    localparam logic [7:0] CMD_FWD        = 8'h01;
    localparam logic [7:0] CMD_LEFT       = 8'h02;
    localparam logic [7:0] CMD_FWD_LEFT   = 8'h03;
    localparam logic [7:0] CMD_BACK       = 8'h04;
    localparam logic [7:0] CMD_BACK_LEFT  = 8'h06;
    localparam logic [7:0] CMD_RIGHT      = 8'h08;
    localparam logic [7:0] CMD_FWD_RIGHT  = 8'h09;
    localparam logic [7:0] CMD_FWD_ALIAS  = 8'h0A;
    localparam logic [7:0] CMD_BACK_RIGHT = 8'h0C;

    function automatic logic is_legal_cmd(input logic [7:0] cmd);
        case (cmd)
            CMD_STOP, CMD_FWD, CMD_LEFT, CMD_FWD_LEFT, CMD_BACK,
            CMD_BACK_LEFT, CMD_RIGHT, CMD_FWD_RIGHT, CMD_FWD_ALIAS,
            CMD_BACK_RIGHT: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arduino_cmd_rx_if.sv
// -----------------------------------------------------------------------------
// arduino_cmd_rx_if
//   Signal bundle between the Arduino serial link and the command receiver.
//   rx               UART line from the Arduino (idles high)
//   arduino_command  last accepted command byte
//   cmd_valid        1-cycle pulse on each accepted byte
//   frame_error      1-cycle pulse when a stop bit is sampled low
//   illegal_cmd      1-cycle pulse when a well-framed byte is not a command
//   link_timeout     level, high while the link watchdog has expired
//   Modports: master = link side (drives rx), slave = receiver.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface arduino_cmd_rx_if;

    logic       rx;
    logic [7:0] arduino_command;
    logic       cmd_valid;
    logic       frame_error;
    logic       illegal_cmd;
    logic       link_timeout;

    modport master (
        output rx,
        input  arduino_command, cmd_valid, frame_error, illegal_cmd, link_timeout
    );

    modport slave (
        input  rx,
        output arduino_command, cmd_valid, frame_error, illegal_cmd, link_timeout
    );

endinterface

// File: rtl/arduino_cmd_rx_uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//   8N1 UART receiver, LSB first: 2-FF synchroniser followed by the RX FSM.
//   clk        system clock
//   reset      synchronous, active-high
//   rx         asynchronous serial input (idles high)
//   data       received byte, valid while byte_done is high
//   byte_done  combinational 1-cycle strobe: stop bit sampled high
//   frame_err  combinational 1-cycle strobe: stop bit sampled low
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx_core #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_done,
    output logic       frame_err
);

    localparam int                CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;

    logic rx_meta, rx_s, rx_s_d;

    // Synchroniser resets to the idle (high) level so that leaving reset never
    // looks like a start edge.
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking = here would let later flops see this cycle's new values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        frame_err = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (rx_s_d && !rx_s) begin
                    state_d = START;
                end
            end

            // Mid-start-bit check rejects short low glitches on an idle line.
            START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end

            DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end

            STOP: begin
                if (baud_q == BIT_LAST) begin
                    baud_d = '0;
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = WAIT_HIGH;
                    end
                end
            end

            // Break or stuck-low line: only a high level re-arms the receiver.
            WAIT_HIGH: begin
                baud_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign data = shift_q;

endmodule

// File: rtl/arduino_cmd_rx.sv
// -----------------------------------------------------------------------------
// arduino_cmd_rx
//   Receives drive-command bytes from the Arduino over UART, keeps the last
//   legal byte for the manual-mode FSM, and forces STOP if the link goes quiet.
//   clk    system clock
//   reset  synchronous, active-high
//   bus    arduino_cmd_rx_if.slave: rx in; arduino_command, cmd_valid,
//          frame_error, illegal_cmd, link_timeout out
//   Parameters: CLK_FREQ (Hz), BAUD (bit/s), TIMEOUT_MS (watchdog interval).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module arduino_cmd_rx
    import drive_cmd_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int TIMEOUT_MS = 200
) (
    input  logic            clk,
    input  logic            reset,
    arduino_cmd_rx_if.slave bus
);

    localparam int             CLKS_PER_BIT   = CLK_FREQ / BAUD;
    localparam int             TIMEOUT_CYCLES = CLK_FREQ / 1000 * TIMEOUT_MS;
    localparam int             WD_W           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT      = WD_W'(TIMEOUT_CYCLES);

    logic [7:0]      rx_data;
    logic            byte_done;
    logic            frame_err;
    logic            legal_byte;
    logic            bad_byte;

    logic [7:0]      cmd_q;
    logic            cmd_valid_q;
    logic            frame_error_q;
    logic            illegal_q;
    logic            link_timeout_q;
    logic [WD_W-1:0] wd_q;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (bus.rx),
        .data      (rx_data),
        .byte_done (byte_done),
        .frame_err (frame_err)
    );

    assign legal_byte = byte_done &&  is_legal_cmd(rx_data);
    assign bad_byte   = byte_done && !is_legal_cmd(rx_data);

    // A legal byte takes priority over watchdog expiry on the same edge.
    // Illegal bytes deliberately leave the watchdog running.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q          <= CMD_STOP;
            cmd_valid_q    <= 1'b0;
            frame_error_q  <= 1'b0;
            illegal_q      <= 1'b0;
            link_timeout_q <= 1'b0;
            wd_q           <= '0;
        end else begin
            cmd_valid_q   <= legal_byte;
            illegal_q     <= bad_byte;
            frame_error_q <= frame_err;

            if (legal_byte) begin
                cmd_q          <= rx_data;
                link_timeout_q <= 1'b0;
                wd_q           <= '0;
            end else if (wd_q != WD_LIMIT) begin
                wd_q <= wd_q + 1'b1;
                if (wd_q == WD_LIMIT - 1'b1) begin
                    cmd_q          <= CMD_STOP;
                    link_timeout_q <= 1'b1;
                end
            end
        end
    end

    assign bus.arduino_command = cmd_q;
    assign bus.cmd_valid       = cmd_valid_q;
    assign bus.frame_error     = frame_error_q;
    assign bus.illegal_cmd     = illegal_q;
    assign bus.link_timeout    = link_timeout_q;

endmodule

// File: tb/tb_arduino_cmd_rx.sv
// -----------------------------------------------------------------------------
// tb_arduino_cmd_rx
//   Self-checking bench for arduino_cmd_rx at 10 clk/bit and a 1000-cycle
//   watchdog. Expected pulses are queued when a frame is driven and compared
//   when the DUT raises a pulse.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_arduino_cmd_rx;

    localparam int BIT_CLKS = 10;
    localparam int WD_CLKS  = 1000;

    typedef enum int {EV_VALID, EV_FRAME, EV_ILLEGAL} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] cmd;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    arduino_cmd_rx_if bus ();

    arduino_cmd_rx #(
        .CLK_FREQ   (1_000_000),
        .BAUD       (100_000),
        .TIMEOUT_MS (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] model_cmd = 8'h00;
    int         last_valid_cyc = 0;
    int         prev_valid_cyc = 0;
    int         frame_start_cyc = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    function automatic logic tb_legal(input logic [7:0] b);
        logic [7:0] legal_list [10] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                                        8'h06, 8'h08, 8'h09, 8'h0A, 8'h0C};
        foreach (legal_list[i]) if (legal_list[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    // Scoreboard monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        int       pulses;
        ev_t      e;
        ev_kind_e obs;
        if (!reset) begin
            pulses = int'(bus.cmd_valid) + int'(bus.frame_error) + int'(bus.illegal_cmd);
            if (pulses != 0) begin
                check("single pulse", pulses, 1);
                obs = bus.cmd_valid ? EV_VALID : (bus.frame_error ? EV_FRAME : EV_ILLEGAL);
                if (exp_q.size() == 0) begin
                    check("unexpected pulse", int'(obs), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse kind", int'(obs), int'(e.kind));
                    check("pulse command", bus.arduino_command, e.cmd);
                    if (e.kind == EV_VALID) begin
                        check("timeout cleared on byte", bus.link_timeout, 1'b0);
                        prev_valid_cyc = last_valid_cyc;
                        last_valid_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is aligned just after a rising edge; leaves rx at the stop level.
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        frame_start_cyc = cyc;
        bus.rx = 1'b0;
        repeat (BIT_CLKS) tick();
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (BIT_CLKS) tick();
        end
        bus.rx = stop_bit;
        repeat (BIT_CLKS) tick();
    endtask

    task automatic send_cmd(input logic [7:0] b);
        ev_t e;
        if (tb_legal(b)) begin
            e.kind    = EV_VALID;
            e.cmd     = b;
            model_cmd = b;
        end else begin
            e.kind = EV_ILLEGAL;
            e.cmd  = model_cmd;
        end
        exp_q.push_back(e);
        drive_frame(b, 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check({tag, " drained"}, exp_q.size(), 0);
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] cmd, input logic lt);
        check({tag, " command"}, bus.arduino_command, cmd);
        check({tag, " link_timeout"}, bus.link_timeout, lt);
        check({tag, " pulses"}, {bus.cmd_valid, bus.frame_error, bus.illegal_cmd}, 3'b000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int   t0;
        ev_t  e;
        logic in_window;

        reset  = 1'b1;
        bus.rx = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check_outputs("reset", 8'h00, 1'b0);
        tick();
        reset = 1'b0;
        repeat (20) tick();

        // 1: legal byte, pulse lands inside the stop bit
        send_cmd(8'h09);
        wait_drain("t1");
        in_window = (last_valid_cyc - frame_start_cyc >= 9 * BIT_CLKS) &&
                    (last_valid_cyc - frame_start_cyc <= 10 * BIT_CLKS);
        check("t1 pulse within stop bit", in_window, 1'b1);
        check_outputs("t1", 8'h09, 1'b0);

        // 2: legal then illegal
        tick();
        send_cmd(8'h01);
        send_cmd(8'h05);
        wait_drain("t2");
        check_outputs("t2", 8'h01, 1'b0);

        // 3: bad stop bit, line held low, then a good byte
        tick();
        e.kind = EV_FRAME;
        e.cmd  = model_cmd;
        exp_q.push_back(e);
        drive_frame(8'h04, 1'b0);
        repeat (50) tick();
        bus.rx = 1'b1;
        repeat (20) tick();
        check("t3 frame error seen", exp_q.size(), 0);
        check("t3 command held", bus.arduino_command, 8'h01);
        send_cmd(8'h02);
        wait_drain("t3");
        check_outputs("t3", 8'h02, 1'b0);

        // 4: short glitch, then the receiver must still accept a byte
        tick();
        bus.rx = 1'b0;
        repeat (3) tick();
        bus.rx = 1'b1;
        repeat (30) tick();
        @(negedge clk);
        check_outputs("t4 glitch", 8'h02, 1'b0);
        tick();
        send_cmd(8'h08);
        wait_drain("t4");
        check_outputs("t4", 8'h08, 1'b0);

        // 5: watchdog expiry exactly WD_CLKS after the update
        tick();
        send_cmd(8'h01);
        wait_drain("t5");
        t0 = last_valid_cyc;
        while (cyc < t0 + WD_CLKS - 1) @(negedge clk);
        check_outputs("t5 before expiry", 8'h01, 1'b0);
        @(negedge clk);
        check_outputs("t5 at expiry", 8'h00, 1'b1);
        model_cmd = 8'h00;
        repeat (20) @(negedge clk);
        check_outputs("t5 expired hold", 8'h00, 1'b1);
        tick();
        send_cmd(8'h0A);
        wait_drain("t5b");
        check_outputs("t5b", 8'h0A, 1'b0);

        // 6: reset in the middle of data bit 4 of 0x0C
        tick();
        bus.rx = 1'b0;
        repeat (BIT_CLKS) tick();
        for (int i = 0; i < 4; i++) begin
            bus.rx = (8'h0C >> i) & 8'h01;
            repeat (BIT_CLKS) tick();
        end
        bus.rx = 1'b0;
        repeat (BIT_CLKS / 2) tick();
        reset  = 1'b1;
        bus.rx = 1'b1;
        repeat (3) tick();
        reset     = 1'b0;
        model_cmd = 8'h00;
        @(negedge clk);
        check_outputs("t6 after reset", 8'h00, 1'b0);
        check("t6 nothing pending", exp_q.size(), 0);
        tick();
        repeat (30) tick();
        send_cmd(8'h03);
        wait_drain("t6");
        check_outputs("t6", 8'h03, 1'b0);

        tick();
        send_cmd(8'h01);
        send_cmd(8'h08);
        wait_drain("t6 b2b");
        check("t6 b2b spacing", last_valid_cyc - prev_valid_cyc, 10 * BIT_CLKS);
        check_outputs("t6 b2b", 8'h08, 1'b0);

        // Watchdog runs from reset with no byte received
        tick();
        reset = 1'b1;
        repeat (2) tick();
        t0    = cyc;
        reset = 1'b0;
        model_cmd = 8'h00;
        while (cyc < t0 + WD_CLKS - 1) @(negedge clk);
        check_outputs("post-reset before expiry", 8'h00, 1'b0);
        @(negedge clk);
        check_outputs("post-reset expiry", 8'h00, 1'b1);

        check("final queue empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
